// File: rtl/countdown_pkg.sv
// Shared types and helpers for the MM:SS countdown timer.
package countdown_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef logic [3:0] bcd_digit_t;

  typedef struct packed {
    logic [7:0] min;
    logic [7:0] sec;
  } mmss_t;

  localparam bcd_digit_t SEC_TENS_MAX = 4'd5;
  localparam bcd_digit_t UNITS_MAX    = 4'd9;

  // Saturate each digit of a two-digit BCD byte to 59.
  function automatic logic [7:0] bcd_clamp(input logic [7:0] v);
    bcd_digit_t t;
    bcd_digit_t u;
    t = v[7:4];
    u = v[3:0];
    if (t > SEC_TENS_MAX) t = SEC_TENS_MAX;
    if (u > UNITS_MAX)    u = UNITS_MAX;
    return {t, u};
  endfunction

endpackage

// File: rtl/countdown_timer_tick_prescaler.sv
// Clock-enable prescaler: counts 0..DIV-1 while enabled, wrap marks the last count.
module tick_prescaler #(
  parameter int unsigned DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic wrap
);

  localparam int unsigned PRESCALE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRESCALE_W-1:0] LAST = PRESCALE_W'(DIV - 1);

  logic [PRESCALE_W-1:0] cnt_q;

  assign wrap = en && (cnt_q == LAST);

  // Counter: clear wins, otherwise advance and wrap while enabled, hold when not.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      cnt_q <= '0;
    else if (clr)    cnt_q <= '0;
    else if (en)     cnt_q <= wrap ? '0 : cnt_q + 1'b1;
  end

endmodule

// File: rtl/countdown_timer.sv
// Loadable BCD MM:SS countdown timer with 1 Hz clock-enable tick.
// Optional build macro COUNTDOWN_AUTO_RELOAD_EN: on expiry reload the saved
// value and keep running, with done as a single-cycle pulse.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 25000000,
  parameter int unsigned TICK_HZ = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_min_bcd,
  input  logic [7:0] load_sec_bcd,
  input  logic       start,
  input  logic       stop,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       running,
  output logic       tick,
  output logic       done
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  localparam bit AUTO_RELOAD = 1'b1;
`else
  localparam bit AUTO_RELOAD = 1'b0;
`endif

  if (DIV < 2) begin : g_div_chk
    $error("countdown_timer: CLK_HZ/TICK_HZ must be >= 2");
  end

  state_e state_q;
  mmss_t  val_q, saved_q, val_dec, val_ld;
  logic   running_q, tick_q, done_q;
  logic   ps_clr, ps_en, ps_wrap;
  logic   go, val_zero, val_one;

  // stop always beats start when both arrive together
  assign go       = start && !stop;
  assign val_ld   = {bcd_clamp(load_min_bcd), bcd_clamp(load_sec_bcd)};
  assign val_zero = (val_q == 16'h0000);
  assign val_one  = (val_q == 16'h0001);

  // Prescaler only advances on RUN edges that are not being interrupted, so a
  // pause freezes the exact count that was showing when stop was sampled.
  assign ps_en  = (state_q == ST_RUN) && !load && !stop;
  assign ps_clr = load || ((state_q == ST_IDLE) && go);

  tick_prescaler #(.DIV(DIV)) u_presc (
    .clk   (clk),
    .reset (reset),
    .clr   (ps_clr),
    .en    (ps_en),
    .wrap  (ps_wrap)
  );

  // BCD decrement with borrow from seconds into minutes; 00:00 never reaches here.
  always_comb begin
    val_dec = val_q;
    if (val_q.sec[3:0] != 4'd0) begin
      val_dec.sec[3:0] = val_q.sec[3:0] - 4'd1;
    end else if (val_q.sec[7:4] != 4'd0) begin
      val_dec.sec = {val_q.sec[7:4] - 4'd1, UNITS_MAX};
    end else begin
      val_dec.sec = {SEC_TENS_MAX, UNITS_MAX};
      if (val_q.min[3:0] != 4'd0) val_dec.min[3:0] = val_q.min[3:0] - 4'd1;
      else                        val_dec.min      = {val_q.min[7:4] - 4'd1, UNITS_MAX};
    end
  end

  // Control FSM with registered value, tick, done and running outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      val_q     <= '0;
      saved_q   <= '0;
      running_q <= 1'b0;
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      if (load) begin
        state_q   <= ST_IDLE;
        val_q     <= val_ld;
        saved_q   <= val_ld;
        done_q    <= 1'b0;
        running_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (go) begin
              if (val_zero) begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q   <= ST_RUN;
                running_q <= 1'b1;
              end
            end
          end
          ST_RUN: begin
            if (stop) begin
              state_q   <= ST_PAUSE;
              running_q <= 1'b0;
            end else begin
              done_q <= 1'b0;
              if (ps_wrap) begin
                tick_q <= 1'b1;
                if (val_one) begin
                  done_q <= 1'b1;
                  if (AUTO_RELOAD && (saved_q != 16'h0000)) begin
                    val_q <= saved_q;
                  end else begin
                    val_q     <= '0;
                    state_q   <= ST_DONE;
                    running_q <= 1'b0;
                  end
                end else begin
                  val_q <= val_dec;
                end
              end
            end
          end
          ST_PAUSE: begin
            if (go) begin
              state_q   <= ST_RUN;
              running_q <= 1'b1;
            end
          end
          ST_DONE: ;
          default: begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign min_bcd = val_q.min;
  assign sec_bcd = val_q.sec;
  assign running = running_q;
  assign tick    = tick_q;
  assign done    = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer at CLK_HZ=10, TICK_HZ=1 (DIV=10).
module tb_countdown_timer;

  logic       clk, rst_n, load, start, stop;
  logic [7:0] ld_min, ld_sec, min_bcd, sec_bcd;
  logic       running, tick, done;

  typedef struct {
    int         cyc;
    logic [7:0] mn;
    logic [7:0] sc;
    logic       dn;
    logic       rn;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  countdown_timer #(.CLK_HZ(10), .TICK_HZ(1)) dut (
    .clk          (clk),
    .reset        (rst_n),
    .load         (load),
    .load_min_bcd (ld_min),
    .load_sec_bcd (ld_sec),
    .start        (start),
    .stop         (stop),
    .min_bcd      (min_bcd),
    .sec_bcd      (sec_bcd),
    .running      (running),
    .tick         (tick),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic [7:0] m, input logic [7:0] s,
                      input logic d, input logic r);
    exp_t e;
    e.cyc = c; e.mn = m; e.sc = s; e.dn = d; e.rn = r;
    sb.push_back(e);
  endtask

  // Monitor: every tick pulse must match the next expected step.
  always @(negedge clk) begin
    if (tick) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_tick: got tick=1 expected none (cyc %0d, %0h:%0h)",
                 cyc, min_bcd, sec_bcd);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("tick_cyc", cyc, e.cyc);
        chk("tick_min", {24'd0, min_bcd}, {24'd0, e.mn});
        chk("tick_sec", {24'd0, sec_bcd}, {24'd0, e.sc});
        chk("tick_done", {31'd0, done}, {31'd0, e.dn});
        chk("tick_running", {31'd0, running}, {31'd0, e.rn});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] m, input logic [7:0] s);
    ld_min = m; ld_sec = s; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic do_start(output int e);
    start = 1'b1;
    step();
    e = cyc;
    start = 1'b0;
  endtask

  task automatic drain(input string nm);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 100) begin
      step();
      k++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: got %0d pending ticks expected 0", nm, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, r;
    rst_n = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0;
    ld_min = 8'h00; ld_sec = 8'h00;
    #2;
    chk("rst_min", {24'd0, min_bcd}, 32'h0);
    chk("rst_sec", {24'd0, sec_bcd}, 32'h0);
    chk("rst_running", {31'd0, running}, 32'h0);
    chk("rst_tick", {31'd0, tick}, 32'h0);
    chk("rst_done", {31'd0, done}, 32'h0);
    step(); step();
    rst_n = 1'b1;
    step();

    // 00:03 counts to expiry
    do_load(8'h00, 8'h03);
    do_start(e);
    chk("run_after_start", {31'd0, running}, 32'h1);
    push(e + 10, 8'h00, 8'h02, 1'b0, 1'b1);
    push(e + 20, 8'h00, 8'h01, 1'b0, 1'b1);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    push(e + 30, 8'h00, 8'h03, 1'b1, 1'b1);
    drain("expiry");
`else
    push(e + 30, 8'h00, 8'h00, 1'b1, 1'b0);
    drain("expiry");
    repeat (5) step();
    chk("done_level", {31'd0, done}, 32'h1);
    chk("done_not_running", {31'd0, running}, 32'h0);
    start = 1'b1; step(); start = 1'b0;
    chk("done_ignores_start", {31'd0, running}, 32'h0);
`endif

    // 01:00 borrows into minutes, tick one cycle wide
    do_load(8'h01, 8'h00);
    chk("load_clears_done", {31'd0, done}, 32'h0);
    do_start(e);
    push(e + 10, 8'h00, 8'h59, 1'b0, 1'b1);
    drain("borrow");
    chk("tick_width", {31'd0, tick}, 32'h0);

    // pause with prescaler at 4, resume continues from held count
    do_load(8'h00, 8'h05);
    do_start(e);
    repeat (4) step();
    stop = 1'b1; step(); stop = 1'b0;
    chk("paused_running", {31'd0, running}, 32'h0);
    repeat (25) step();
    chk("paused_value", {24'd0, sec_bcd}, 32'h05);
    do_start(r);
    push(r + 6, 8'h00, 8'h04, 1'b0, 1'b1);
    drain("resume");

    // start+stop together from PAUSE stays paused
    stop = 1'b1; step(); stop = 1'b0;
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    chk("start_stop_pause", {31'd0, running}, 32'h0);
    repeat (12) step();

    // clamp on load
    do_load(8'h9A, 8'h7C);
    chk("clamp_min", {24'd0, min_bcd}, 32'h59);
    chk("clamp_sec", {24'd0, sec_bcd}, 32'h59);
    chk("load_idle", {31'd0, running}, 32'h0);

    // start at 00:00 goes straight to DONE without a tick
    do_load(8'h00, 8'h00);
    do_start(e);
    chk("zero_done", {31'd0, done}, 32'h1);
    chk("zero_running", {31'd0, running}, 32'h0);
    repeat (15) step();

    // async reset mid-run
    do_load(8'h00, 8'h42);
    do_start(e);
    repeat (3) step();
    rst_n = 1'b0;
    #2;
    chk("arst_min", {24'd0, min_bcd}, 32'h0);
    chk("arst_sec", {24'd0, sec_bcd}, 32'h0);
    chk("arst_running", {31'd0, running}, 32'h0);
    chk("arst_done", {31'd0, done}, 32'h0);
    #1 rst_n = 1'b1;
    repeat (15) step();
    chk("arst_idle", {31'd0, running}, 32'h0);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    do_load(8'h00, 8'h02);
    do_start(e);
    push(e + 10, 8'h00, 8'h01, 1'b0, 1'b1);
    push(e + 20, 8'h00, 8'h02, 1'b1, 1'b1);
    push(e + 30, 8'h00, 8'h01, 1'b0, 1'b1);
    push(e + 40, 8'h00, 8'h02, 1'b1, 1'b1);
    drain("reload");
    chk("reload_done_pulse", {31'd0, done}, 32'h0);
    chk("reload_running", {31'd0, running}, 32'h1);
    do_load(8'h00, 8'h00);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable MM:SS countdown timer; the downward-counting companion to the free-running up-counter/1 Hz divider in the same design.
- Derives a 1 Hz tick from the system clock with a single-clock clock-enable. No generated clocks.
- Counts a BCD minutes:seconds value down to 00:00 and flags expiry.
- Outputs feed the 7-segment/LED display logic and alarm logic.

Parameters:
- CLK_HZ, 25000000, system clock frequency in Hz.
- TICK_HZ, 1, countdown rate. DIV = CLK_HZ/TICK_HZ. DIV must be ≥2 (elaboration error otherwise).
- PRESCALE_W, $clog2(DIV), prescaler width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- load  in  1  level-sampled; loads load_min_bcd/load_sec_bcd.
- load_min_bcd  in  8  minutes, two BCD digits, 00–59.
- load_sec_bcd  in  8  seconds, two BCD digits, 00–59.
- start  in  1  single-cycle request to run or resume.
- stop  in  1  single-cycle request to pause.
- min_bcd  out  8  current minutes, BCD.
- sec_bcd  out  8  current seconds, BCD.
- running  out  1  high while in RUN.
- tick  out  1  registered 1-cycle pulse on every countdown step.
- done  out  1  expiry flag (level; see Optional Feature).

Behaviour:
- Reset (reset=0, async): state IDLE, prescaler 0, min_bcd=00, sec_bcd=00, saved value 00:00, running=0, tick=0, done=0. Reset mid-run aborts immediately; no residual tick.
- States: IDLE, RUN, PAUSE, DONE. running = (state==RUN), registered.
- Priority per edge: load > stop > start. start and stop in the same cycle means stop wins.
- load, any state:
  - Next state IDLE; prescaler cleared; done cleared.
  - Value and saved value take the clamped inputs.
  - Clamp per digit: tens >5 becomes 5; units >9 becomes 9 (e.g. 8'h7C loads as 8'h59).
- IDLE + start:
  - Value ≠00:00: state RUN, prescaler 0.
  - Value =00:00: state DONE, done=1 on that edge, no tick.
- RUN:
  - Prescaler counts 0..DIV-1 and wraps.
  - On the edge where the prescaler wraps: tick=1 for one cycle and the value decrements on that same edge.
  - First tick comes on the DIV-th edge after the edge that accepted start.
- Decrement: sec units borrow from sec tens. At sec=00, sec becomes 59 and minutes decrement (BCD borrow). Minutes never underflow because the 00:00 check comes first.
- Expiry: a tick with value 00:01 sets value 00:00, state DONE and done=1 on the same edge.
- RUN + stop: state PAUSE. The prescaler holds its count (not cleared). No tick while paused.
- PAUSE + start: state RUN; the prescaler resumes from the held count.
- DONE: start and stop are ignored; done stays high until load or reset.
- stop in IDLE or PAUSE: no effect.
- tick is 0 in every state except RUN.

Optional Feature:
- Macro: COUNTDOWN_AUTO_RELOAD_EN.
- Defined:
  - On expiry, the value reloads from the saved value on the same edge and the state stays RUN.
  - done is a 1-cycle pulse per expiry; the prescaler continues without restart.
  - If the saved value is 00:00, behaviour matches the undefined case (enter DONE).
- Undefined: behaviour as above; done is a level held until load or reset; the saved value register is still kept but unused.

Decomposition:
- Package countdown_pkg holds:
  - state enum (IDLE, RUN, PAUSE, DONE), 2 bits.
  - BCD digit typedef (4 bits) and MM:SS struct (two bytes).
  - Constants SEC_TENS_MAX=5, UNITS_MAX=9.
  - Function bcd_clamp.
- One sub-module: tick_prescaler.
  - Parameter DIV.
  - Inputs clk, reset, clr, en; output wrap.
  - Counter plus terminal compare.
- The top holds the FSM and BCD arithmetic.

Test Plan (CLK_HZ=10, TICK_HZ=1, so DIV=10):
- Reset then load 00:03, start → tick on edges +10, +20, +30 after start. Value goes 00:02, 00:01, 00:00. done=1 and running=0 on edge +30.
- Load 01:00, start, wait one tick → value 00:59, tick high exactly 1 cycle.
- Load 00:05, start; stop at prescaler=4; hold 25 cycles; start → no tick while paused. Next tick 6 edges after resume; value 00:04.
- Start and stop in the same cycle from PAUSE → stays PAUSE. Load 8'h9A / 8'h7C → value 59:59 (clamped).
- Start with value 00:00 → DONE next edge, done=1, tick never asserted.
- Reset pulsed low mid-RUN (value 00:42) → outputs clear asynchronously. With COUNTDOWN_AUTO_RELOAD_EN: load 00:02 → done pulses 1 cycle every 20 cycles and running stays 1.
